// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO write-side request generator.
package fifo_pkg;

  localparam int unsigned DEB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_REL = 2'd2
  } wr_state_t;

endpackage

// File: rtl/wr_btn_filter.sv
// Two-flop synchronizer plus level debouncer for the write push-button.
import fifo_pkg::*;

module wr_btn_filter #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic wclk,
  input  logic wrst_n,
  input  logic btn_raw,
  output logic btn_deb,
  output logic btn_rise
);

  logic                 sync_q1;
  logic                 sync_q2;
  logic [DEB_CNT_W-1:0] deb_cnt;
  logic                 deb_hit_c;

  // Accept the new level on the DEB_CYCLES-th consecutive differing sample.
  assign deb_hit_c = (sync_q2 != btn_deb) &&
                     (deb_cnt == DEB_CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      btn_deb  <= 1'b0;
      btn_rise <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_rise <= deb_hit_c && sync_q2;
      if (sync_q2 == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_hit_c) begin
        btn_deb <= sync_q2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wr_req_gen.sv
// Turns debounced button presses into single FIFO write strobes with
// saturating accept/drop counters and a sticky overflow flag.
import fifo_pkg::*;

module wr_req_gen #(
  parameter int unsigned DSIZE      = 3,
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned CSIZE      = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             btn_raw,
  input  logic [DSIZE-1:0] din,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             overflow,
  output logic [CSIZE-1:0] wr_count,
  output logic [CSIZE-1:0] drop_count
);

  wr_state_t        state;
  wr_state_t        state_nxt;
  logic             btn_deb;
  logic             btn_rise;
  logic [DSIZE-1:0] din_q;
  logic [DSIZE-1:0] pend_data;
  logic             capture_c;
  logic             write_c;
  logic             drop_c;

  wr_btn_filter #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_filter (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .btn_raw (btn_raw),
    .btn_deb (btn_deb),
    .btn_rise(btn_rise)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) din_q <= '0;
    else         din_q <= din;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (btn_rise) state_nxt = FIRE;
      FIRE:     state_nxt = WAIT_REL;
      WAIT_REL: if (!btn_deb) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // wfull is only looked at while in FIRE.
  always_comb begin
    capture_c = 1'b0;
    write_c   = 1'b0;
    drop_c    = 1'b0;
    if (state == IDLE && btn_rise) capture_c = 1'b1;
    if (state == FIRE) begin
      write_c = !wfull;
      drop_c  = wfull;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      winc       <= 1'b0;
      wdata      <= '0;
      pend_data  <= '0;
      overflow   <= 1'b0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      winc <= write_c;
      if (capture_c) pend_data <= din_q;
      if (write_c) begin
        wdata <= pend_data;
        if (wr_count != '1) wr_count <= wr_count + CSIZE'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CSIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_wr_req_gen.sv
// Directed self-checking bench for wr_req_gen (default and CSIZE=2 instances).
`timescale 1ns/1ps

module tb_wr_req_gen;

  logic       wclk;
  logic       wrst_n;
  logic       btn_raw;
  logic [2:0] din;
  logic       wfull;

  logic       winc,      winc_s;
  logic [2:0] wdata,     wdata_s;
  logic       overflow,  overflow_s;
  logic [7:0] wr_count,  drop_count;
  logic [1:0] wr_count_s, drop_count_s;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int lat;
  int p0;

  wr_req_gen dut (
    .wclk(wclk), .wrst_n(wrst_n), .btn_raw(btn_raw), .din(din), .wfull(wfull),
    .winc(winc), .wdata(wdata), .overflow(overflow),
    .wr_count(wr_count), .drop_count(drop_count)
  );

  wr_req_gen #(.DSIZE(3), .DEB_CYCLES(3), .CSIZE(2)) dut_sat (
    .wclk(wclk), .wrst_n(wrst_n), .btn_raw(btn_raw), .din(din), .wfull(wfull),
    .winc(winc_s), .wdata(wdata_s), .overflow(overflow_s),
    .wr_count(wr_count_s), .drop_count(drop_count_s)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(negedge wclk) if (winc === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_winc(output int n);
    n = 0;
    while (winc !== 1'b1 && n < 20) begin
      @(negedge wclk);
      n++;
    end
  endtask

  // Hold the button for 'hold' cycles, release, then let release debounce settle.
  task automatic press(input int hold);
    btn_raw = 1'b1;
    repeat (hold) @(posedge wclk);
    #1 btn_raw = 1'b0;
    repeat (12) @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst_n  = 1'b0;
    btn_raw = 1'b0;
    din     = 3'd0;
    wfull   = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    check("rst_winc",  32'(winc), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_wrc",   32'(wr_count), 0);
    check("rst_drc",   32'(drop_count), 0);
    wrst_n = 1'b1;
    repeat (2) @(posedge wclk);
    #1;

    // Bounce: toggling each cycle never survives the debouncer.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      btn_raw = ~btn_raw;
      @(posedge wclk);
      #1;
    end
    btn_raw = 1'b0;
    repeat (15) @(posedge wclk);
    #1;
    check("bounce_pulses", 32'(pulses - p0), 0);
    check("bounce_wrc",    32'(wr_count), 0);
    check("bounce_drc",    32'(drop_count), 0);

    // Clean press with latency measurement.
    din = 3'b101;
    p0  = pulses;
    btn_raw = 1'b1;
    wait_winc(lat);
    check("clean_latency", 32'(lat >= 6 && lat <= 8), 1);
    check("clean_wdata_at_winc", 32'(wdata), 5);
    repeat (10) @(posedge wclk);
    #1 btn_raw = 1'b0;
    repeat (12) @(posedge wclk);
    #1;
    check("clean_pulses", 32'(pulses - p0), 1);
    check("clean_wrc",    32'(wr_count), 1);
    check("clean_wdata_hold", 32'(wdata), 5);
    check("clean_ovf",    32'(overflow), 0);

    // Full FIFO: press dropped, wdata keeps last written value.
    wfull = 1'b1;
    din   = 3'd7;
    p0    = pulses;
    press(10);
    check("full_pulses", 32'(pulses - p0), 0);
    check("full_ovf",    32'(overflow), 1);
    check("full_drc",    32'(drop_count), 1);
    check("full_wdata",  32'(wdata), 5);
    wfull = 1'b0;
    din   = 3'd2;
    p0    = pulses;
    press(10);
    check("after_full_pulses", 32'(pulses - p0), 1);
    check("after_full_wdata",  32'(wdata), 2);
    check("after_full_ovf",    32'(overflow), 1);
    check("after_full_wrc",    32'(wr_count), 2);

    // Long hold yields a single write; a second press yields another.
    din = 3'd6;
    p0  = pulses;
    press(100);
    check("long_pulses", 32'(pulses - p0), 1);
    check("long_wdata",  32'(wdata), 6);
    din = 3'd3;
    press(10);
    check("long2_pulses", 32'(pulses - p0), 2);
    check("long2_wrc",    32'(wr_count), 4);
    check("long2_wdata",  32'(wdata), 3);

    // Reset while the strobe is up; held button fires again after release.
    din = 3'd4;
    btn_raw = 1'b1;
    wait_winc(lat);
    check("rstmid_saw_winc", 32'(winc), 1);
    #1 wrst_n = 1'b0;
    #1;
    check("rstmid_winc",  32'(winc), 0);
    check("rstmid_wdata", 32'(wdata), 0);
    check("rstmid_ovf",   32'(overflow), 0);
    check("rstmid_wrc",   32'(wr_count), 0);
    check("rstmid_drc",   32'(drop_count), 0);
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
    p0 = pulses;
    wait_winc(lat);
    check("rstmid_relat", 32'(lat >= 6 && lat <= 9), 1);
    repeat (5) @(posedge wclk);
    #1 btn_raw = 1'b0;
    repeat (12) @(posedge wclk);
    #1;
    check("rstmid_pulses", 32'(pulses - p0), 1);
    check("rstmid_wrc2",   32'(wr_count), 1);
    check("rstmid_wdata2", 32'(wdata), 4);

    // Saturation: narrow counter sticks at all-ones.
    for (int i = 0; i < 5; i++) press(9);
    check("sat_wrc_wide",   32'(wr_count), 6);
    check("sat_wrc_narrow", 32'(wr_count_s), 3);
    check("sat_drc_narrow", 32'(drop_count_s), 0);
    check("sat_ovf_narrow", 32'(overflow_s), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
